// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one cordic core between two requesters,
// with a done-timeout watchdog that aborts a stuck transaction.
module cordic_arbiter #(
  parameter int unsigned THETA_W  = 23,
  parameter int unsigned RESULT_W = 22,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic [1:0]          req_valid,
  input  logic [THETA_W-1:0]  req_theta0,
  input  logic [THETA_W-1:0]  req_theta1,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [RESULT_W-1:0] rsp_result,
  output logic                busy,
  output logic                core_start,
  output logic [THETA_W-1:0]  core_theta,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_result
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [THETA_W-1:0]  core_theta_q, core_theta_d;
  logic [RESULT_W-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_err_q, rsp_err_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic                core_start_q, core_start_d;
  logic                busy_q, busy_d;

  logic                grant_c;
  logic [1:0]          ready_c;

  // Grant selection: a lone requester wins, contention alternates away from last winner.
  always_comb begin
    grant_c = 1'b0;
    case (req_valid)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = ~last_grant_q;
      default: grant_c = 1'b0;
    endcase
    ready_c = 2'b00;
    if ((state_q == S_IDLE) && clk_en && reset && (|req_valid)) begin
      ready_c = grant_c ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    core_theta_d = core_theta_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = 2'b00;
    core_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          core_theta_d = grant_c ? req_theta1 : req_theta0;
          owner_d      = grant_c;
          last_grant_d = grant_c;
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes precedence over a coincident timeout.
        if (core_done) begin
          rsp_result_d = core_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
          state_d      = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Disabled cycles freeze everything, so a pending start pulse stretches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      core_theta_q <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 2'b00;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      core_theta_q <= core_theta_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = ready_c;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;
  assign core_start = core_start_q;
  assign core_theta = core_theta_q;

endmodule
